// File: rtl/dev_pulsegen_pkg.sv
// -----------------------------------------------------------------------------
// dev_pulsegen_pkg
// Shared definitions for the pulse burst generator: default field widths,
// the FSM state encoding and a small helper that derives the edge strobes
// from the old and new pin level.
// -----------------------------------------------------------------------------
package dev_pulsegen_pkg;

   localparam int CW_DEF = 16;
   localparam int NW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Returns {rise, fall} for a pin moving from old_lvl to new_lvl.
   // The two bits can never be set together.
   function automatic logic [1:0] edge_strobes(input logic old_lvl, input logic new_lvl);
      edge_strobes = {~old_lvl & new_lvl, old_lvl & ~new_lvl};
   endfunction

endpackage

// File: rtl/dev_pulsegen_phase_cnt.sv
// -----------------------------------------------------------------------------
// dev_phase_cnt
// Loadable down-counter that times one phase (active or inactive) of a pulse.
// A zero load value is clamped to 1 so that every phase lasts at least one
// cycle. The counter stops at 0 instead of wrapping.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset, clears the count
//   load   load value (clamped) on this edge
//   value  phase length in cycles
//   last   high while the count is 1, i.e. the current cycle ends the phase
// -----------------------------------------------------------------------------
module dev_phase_cnt
   import dev_pulsegen_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] value,
   output logic          last
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] load_val;

   assign load_val = (value == '0) ? CW'(1) : value;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign last = (cnt == CW'(1));

endmodule

// File: rtl/dev_pulsegen.sv
// -----------------------------------------------------------------------------
// dev_pulsegen
// Drives one device pin with a burst of count pulses, each high_len cycles
// active followed by low_len cycles inactive. Pin and edge strobes are fully
// registered. A start/busy/done handshake connects it to the bus logic.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   start     one-cycle request, only sampled while busy=0
//   high_len  active phase length in cycles (0 acts as 1)
//   low_len   inactive phase length in cycles (0 acts as 1)
//   count     number of pulses (0 completes immediately)
//   polarity  0: idle low / active high, 1: idle high / active low
//   abort     terminate the running burst, pin returns to idle
//   pin       registered pin drive
//   busy      burst in progress
//   done      one-cycle strobe on normal completion
//   rise      one-cycle strobe when pin goes 0->1
//   fall      one-cycle strobe when pin goes 1->0
// -----------------------------------------------------------------------------
module dev_pulsegen
   import dev_pulsegen_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int NW = NW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] high_len,
   input  logic [CW-1:0] low_len,
   input  logic [NW-1:0] count,
   input  logic          polarity,
   input  logic          abort,
   output logic          pin,
   output logic          busy,
   output logic          done,
   output logic          rise,
   output logic          fall
);

   state_t        state;
   logic          pol_q;
   logic [CW-1:0] high_q;
   logic [CW-1:0] low_q;
   logic [NW-1:0] pulse_q;

   logic          phase_last;
   logic          cnt_load;
   logic [CW-1:0] cnt_value;
   logic          pin_n;
   logic [1:0]    strobes_n;
   logic          accept;
   logic          more_pulses;

   // abort has priority over start while idle, so it blocks acceptance.
   assign accept      = (state == IDLE) && start && !abort;
   assign more_pulses = (pulse_q > NW'(1));

   dev_phase_cnt #(
      .CW(CW)
   ) u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .value (cnt_value),
      .last  (phase_last)
   );

   // Phase counter reloads at the start of every phase. On the accepting
   // edge the live high_len is used, since the latched copy is not yet valid.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_value = high_q;
      case (state)
         IDLE: begin
            if (accept && (count != '0)) begin
               cnt_load  = 1'b1;
               cnt_value = high_len;
            end
         end
         HIGH: begin
            if (!abort && phase_last) begin
               cnt_load  = 1'b1;
               cnt_value = low_q;
            end
         end
         LOW: begin
            if (!abort && phase_last && more_pulses) begin
               cnt_load  = 1'b1;
               cnt_value = high_q;
            end
         end
         default: begin
            cnt_load  = 1'b0;
            cnt_value = high_q;
         end
      endcase
   end

   // Next pin level. Computed separately so the strobes can compare it with
   // the current pin and stay aligned with the registered pin edge.
   always_comb begin
      pin_n = pin;
      case (state)
         IDLE: begin
            if (accept) begin
               pin_n = (count != '0) ? ~polarity : polarity;
            end
         end
         HIGH: begin
            if (abort || phase_last) begin
               pin_n = pol_q;
            end
         end
         LOW: begin
            if (abort) begin
               pin_n = pol_q;
            end else if (phase_last) begin
               pin_n = more_pulses ? ~pol_q : pol_q;
            end
         end
         default: pin_n = pol_q;
      endcase
   end

   assign strobes_n = edge_strobes(pin, pin_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pin     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         pol_q   <= 1'b0;
         high_q  <= '0;
         low_q   <= '0;
         pulse_q <= '0;
      end else begin
         done <= 1'b0;
         pin  <= pin_n;
         rise <= strobes_n[1];
         fall <= strobes_n[0];
         case (state)
            IDLE: begin
               if (accept) begin
                  pol_q  <= polarity;
                  high_q <= high_len;
                  low_q  <= low_len;
                  if (count != '0) begin
                     state   <= HIGH;
                     busy    <= 1'b1;
                     pulse_q <= count;
                  end else begin
                     pulse_q <= '0;
                     done    <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (phase_last) begin
                  state <= LOW;
               end
            end
            LOW: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (phase_last) begin
                  pulse_q <= pulse_q - NW'(1);
                  if (more_pulses) begin
                     state <= HIGH;
                  end else begin
                     // Final inactive phase finished: this is the only
                     // path that produces a completion strobe for a burst.
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dev_pulsegen.sv
// -----------------------------------------------------------------------------
// tb_dev_pulsegen
// Directed stimulus table for dev_pulsegen. Each row gives the inputs applied
// before one rising edge and the hand-derived {pin,busy,done,rise,fall}
// expected just after that edge.
// -----------------------------------------------------------------------------
module tb_dev_pulsegen;

   localparam int CW = 16;
   localparam int NW = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] high_len;
   logic [CW-1:0] low_len;
   logic [NW-1:0] count;
   logic          polarity;
   logic          abort;
   logic          pin;
   logic          busy;
   logic          done;
   logic          rise;
   logic          fall;

   typedef struct {
      logic          r;
      logic          s;
      logic          a;
      logic [CW-1:0] h;
      logic [CW-1:0] l;
      logic [NW-1:0] n;
      logic          p;
      logic [4:0]    e;
   } row_t;

   row_t rows[$];
   int   assertions;
   int   failures;

   dev_pulsegen #(
      .CW(CW),
      .NW(NW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .high_len (high_len),
      .low_len  (low_len),
      .count    (count),
      .polarity (polarity),
      .abort    (abort),
      .pin      (pin),
      .busy     (busy),
      .done     (done),
      .rise     (rise),
      .fall     (fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [4:0] act, input logic [4:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: {pin,busy,done,rise,fall} got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input row_t rw);
      rst      = rw.r;
      start    = rw.s;
      abort    = rw.a;
      high_len = rw.h;
      low_len  = rw.l;
      count    = rw.n;
      polarity = rw.p;
   endtask

   task automatic addRow(input logic r, input logic s, input logic a, input int h,
                         input int l, input int n, input logic p, input logic [4:0] e);
      row_t rw;
      rw.r = r;
      rw.s = s;
      rw.a = a;
      rw.h = CW'(h);
      rw.l = CW'(l);
      rw.n = NW'(n);
      rw.p = p;
      rw.e = e;
      rows.push_back(rw);
   endtask

   // Idle/non-start row: inputs carry junk values that must be ignored.
   task automatic addIdle(input logic [4:0] e);
      addRow(1'b0, 1'b0, 1'b0, 9, 9, 9, 1'b1, e);
   endtask

   task automatic buildTable();
      // Reset
      addRow(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 5'b00000);
      addRow(1'b1, 1'b1, 1'b0, 3, 3, 3, 1'b1, 5'b00000);
      addIdle(5'b00000);

      // H=3 L=2 N=2 pol=0
      addRow(1'b0, 1'b1, 1'b0, 3, 2, 2, 1'b0, 5'b11010);
      addIdle(5'b11000);
      addIdle(5'b11000);
      addIdle(5'b01001);
      addIdle(5'b01000);
      addIdle(5'b11010);
      addIdle(5'b11000);
      addIdle(5'b11000);
      addIdle(5'b01001);
      addIdle(5'b01000);
      addIdle(5'b00100);
      addIdle(5'b00000);

      // N=0: immediate done, pin stays low
      addRow(1'b0, 1'b1, 1'b0, 5, 5, 0, 1'b0, 5'b00100);
      addIdle(5'b00000);

      // H=0 L=0 N=3: toggles every cycle
      addRow(1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b0, 5'b11010);
      addIdle(5'b01001);
      addIdle(5'b11010);
      addIdle(5'b01001);
      addIdle(5'b11010);
      addIdle(5'b01001);
      addIdle(5'b00100);
      addIdle(5'b00000);

      // H=10 L=10 N=5, abort before edge 4
      addRow(1'b0, 1'b1, 1'b0, 10, 10, 5, 1'b0, 5'b11010);
      addIdle(5'b11000);
      addIdle(5'b11000);
      addIdle(5'b11000);
      addRow(1'b0, 1'b0, 1'b1, 9, 9, 9, 1'b1, 5'b00001);
      addIdle(5'b00000);
      addIdle(5'b00000);

      // H=4 L=4 N=1, starts while busy ignored, restart in the done cycle
      addRow(1'b0, 1'b1, 1'b0, 4, 4, 1, 1'b0, 5'b11010);
      addIdle(5'b11000);
      addRow(1'b0, 1'b1, 1'b0, 1, 1, 3, 1'b0, 5'b11000);
      addIdle(5'b11000);
      addIdle(5'b01001);
      addIdle(5'b01000);
      addRow(1'b0, 1'b1, 1'b0, 1, 1, 3, 1'b0, 5'b01000);
      addIdle(5'b01000);
      addIdle(5'b00100);
      addRow(1'b0, 1'b1, 1'b0, 1, 1, 1, 1'b0, 5'b11010);
      addIdle(5'b01001);
      addIdle(5'b00100);
      addIdle(5'b00000);

      // pol=1: idle level change, then H=2 L=1 N=1 active-low burst
      addRow(1'b0, 1'b1, 1'b0, 2, 2, 0, 1'b1, 5'b10110);
      addIdle(5'b10000);
      addRow(1'b0, 1'b1, 1'b0, 2, 1, 1, 1'b1, 5'b01001);
      addIdle(5'b01000);
      addIdle(5'b11010);
      addIdle(5'b10100);
      addIdle(5'b10000);
      // abort together with start in idle: abort wins
      addRow(1'b0, 1'b1, 1'b1, 3, 3, 2, 1'b0, 5'b10000);
      addIdle(5'b10000);
      // reset in the middle of a burst
      addRow(1'b0, 1'b1, 1'b0, 1, 5, 2, 1'b1, 5'b01001);
      addIdle(5'b11010);
      addRow(1'b1, 1'b0, 1'b0, 9, 9, 9, 1'b1, 5'b00000);
      addIdle(5'b00000);
   endtask

   initial begin
      assertions = 0;
      failures   = 0;
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      high_len   = '0;
      low_len    = '0;
      count      = '0;
      polarity   = 1'b0;
      buildTable();
      $display("[TB] running %0d directed rows", rows.size());
      @(posedge clk);
      #1;
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("row%0d", i), {pin, busy, done, rise, fall}, rows[i].e);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/dev_pulsegen.md
Name: dev_pulsegen

Overview:
Output-side counterpart of the pin input filter. Drives a single device pin with a programmed burst of pulses: N pulses, each H cycles active and L cycles inactive. Output is glitch-free and fully registered. The block emits rise/fall strobes aligned to its own pin edges and uses a start/busy/done handshake toward the hs32 peripheral bus logic.

Parameters:
CW, 16, width of high/low phase length fields (cycles)
NW, 8, width of pulse count field

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only when busy=0
high_len  in  CW  active phase length H in cycles (0 treated as 1)
low_len  in  CW  inactive phase length L in cycles (0 treated as 1)
count  in  NW  number of pulses N (0 = no pulse, immediate done)
polarity  in  1  0: active-high pulses, idle low; 1: active-low pulses, idle high
abort  in  1  terminate burst; pin returns to idle level
pin  out  1  registered pin drive
busy  out  1  burst in progress
done  out  1  one-cycle strobe at normal burst completion
rise  out  1  one-cycle strobe in the cycle pin first reads 1 after a 0
fall  out  1  one-cycle strobe in the cycle pin first reads 0 after a 1

Behaviour:
- Reset: state IDLE; pin=0, busy=0, done=0, rise=0, fall=0; latched polarity=0, counters=0.
- Latching: high_len, low_len, count and polarity are latched on the accepting edge. Later input changes have no effect until the next accepted start.
- Idle pin level is the latched polarity.
- States: IDLE, HIGH, LOW.
- IDLE, start=1, abort=0, count!=0:
  - On that edge: state->HIGH, busy=1, pin=~pol, phase counter=max(H,1), pulse counter=N.
- IDLE, start=1, count==0: stay IDLE, busy stays 0, done=1 for one cycle. The new polarity is applied to pin on that same edge.
- HIGH: pin is active for exactly max(H,1) cycles, then state->LOW and pin=pol.
- LOW: pin is inactive for exactly max(L,1) cycles. Then:
  - If pulses remain: state->HIGH.
  - On the last pulse: state->IDLE, busy=0, done=1 for one cycle.
- The final low phase is always completed before done, so back-to-back bursts keep a minimum gap of L.
- Latency: if start is sampled at edge 0, done is high in the cycle after edge N*(max(H,1)+max(L,1)). busy is high over exactly that span.
- start while busy=1: ignored. No queuing, no effect on the running burst.
- Restart: start in the same cycle done is high is accepted, because busy is already 0.
- abort while busy: on the next edge state->IDLE, pin=pol, busy=0, done stays 0. fall or rise fires if pin changed.
- abort with start in IDLE: abort wins and start is ignored. abort in IDLE alone has no effect.
- rise/fall: registered with pin, derived from the old vs new pin value on the same edge. They never assert together and are never asserted during reset.
- A polarity change between bursts produces a rise/fall strobe on the accepting edge, reflecting the idle-level change.
- Counters: phase counter counts down to 1 and reloads; no wrap. The pulse counter decrements at each LOW->HIGH or LOW->IDLE transition.
- rst in mid-burst returns every output to its reset value on that edge.

Decomposition:
- Shared dev_defs include: state encoding localparams (IDLE=2'd0, HIGH=2'd1, LOW=2'd2).
- One sub-module is natural: dev_phase_cnt, a CW-bit loadable down-counter. Inputs: load, value (with 0->1 clamp); output: last flag.
- FSM, pulse counter and strobes stay in dev_pulsegen.

Test Plan:
- H=3, L=2, N=2, pol=0, start at edge 0 -> pin=1 edges 0–3, 0 edges 3–5, 1 edges 5–8, 0 edges 8–10; done high one cycle after edge 10; rise at edges 0 and 5, fall at edges 3 and 8.
- N=0 -> busy never asserts, done one cycle after the accepting edge, pin unchanged at 0, no strobes.
- H=0, L=0, N=3 -> pin toggles every cycle (1,0,1,0,1,0); done after edge 6.
- H=10, L=10, N=5, abort at cycle 4 -> pin=0 and busy=0 after the next edge, fall strobe, no done.
- Burst H=4, L=4, N=1; second start with different lengths at cycles 2 and 6 -> ignored, waveform unchanged. Start in the done cycle -> accepted immediately.
- pol=1, H=2, L=1, N=1 from reset -> rise at the accepting edge (idle 1), pin 0 for 2 cycles (fall), then 1 for 1 cycle (rise), then done; rst mid-burst -> all outputs 0 next edge.
